// File: rtl/ft600_fifo_core.sv
// FT600 245 synchronous-FIFO bus engine.
// Moves 16-bit words between an RX FIFO (FT600 -> host) and a TX FIFO
// (host -> FT600), arbitrating bus direction and sequencing OE_N/RD_N/WR_N.
// Runs entirely in the FT600 CLK domain.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | bus released; arbitrate between RX and TX requests
// RX_TURN   | oe_n low one cycle so the FT600 can take over the bus
// RX_READ   | rd_n low; one word captured per edge while rxf_n is low
// RX_END    | rd_n high, oe_n still low one more cycle before release
// TX_WRITE  | data driven, wr_n low; one word accepted per edge with txe_n low
// TX_END    | data released, wr_n high one cycle before IDLE
module ft600_fifo_core #(
   parameter int RX_AW     = 9,
   parameter int TX_AW     = 9,
   parameter int MAX_BURST = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] ft_data_i,
   output logic [15:0] ft_data_o,
   output logic        ft_data_oe,
   input  logic [1:0]  ft_be_i,
   output logic [1:0]  ft_be_o,
   input  logic        ft_rxf_n,
   input  logic        ft_txe_n,
   output logic        ft_oe_n,
   output logic        ft_rd_n,
   output logic        ft_wr_n,
   input  logic        rx_en,
   output logic [17:0] rx_data,
   output logic        rx_valid,
   input  logic        tx_en,
   input  logic [15:0] tx_data,
   output logic        tx_full
);

   localparam int BW = $clog2(MAX_BURST + 1);
   localparam logic [RX_AW:0] RX_FULL = {1'b1, {RX_AW{1'b0}}};
   localparam logic [TX_AW:0] TX_FULL = {1'b1, {TX_AW{1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_RX_TURN,
      S_RX_READ,
      S_RX_END,
      S_TX_WRITE,
      S_TX_END
   } state_t;

   state_t state, state_n;

   logic oe_n_q, rd_n_q, wr_n_q, data_oe_q;
   logic oe_n_n, rd_n_n, wr_n_n, data_oe_n;
   logic [BW-1:0] burst_cnt, burst_n, burst_inc;
   logic last_tx, last_tx_n;

   // ---------------- RX FIFO ----------------
   logic [17:0]      rx_mem [2**RX_AW];
   logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
   logic [RX_AW:0]   rx_count, rx_free, rx_free_after;
   logic             rx_capture, rx_do_push, rx_do_pop, rx_full;

   // A word is on the pins whenever our strobe is low and the FT600 has data.
   assign rx_capture = !rd_n_q && !ft_rxf_n;
   assign rx_full    = (rx_count == RX_FULL);
   assign rx_do_pop  = rx_en && (rx_count != '0);
   assign rx_do_push = rx_capture && (!rx_full || rx_do_pop);
   assign rx_free    = RX_FULL - rx_count;
   assign rx_free_after = rx_free - (RX_AW + 1)'(rx_do_push);
   assign rx_valid   = (rx_count != '0);
   assign rx_data    = rx_mem[rx_rd_ptr];

   // RX storage; contents need no reset since validity is tracked by the count.
   always_ff @(posedge clk) begin
      if (rx_do_push) rx_mem[rx_wr_ptr] <= {ft_be_i, ft_data_i};
   end

   // RX pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
      end else begin
         if (rx_do_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
         if (rx_do_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
         rx_count <= rx_count + (RX_AW + 1)'(rx_do_push) - (RX_AW + 1)'(rx_do_pop);
      end
   end

   // ---------------- TX FIFO ----------------
   logic [15:0]      tx_mem [2**TX_AW];
   logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
   logic [TX_AW:0]   tx_count, tx_count_after;
   logic             tx_accept, tx_do_push, tx_do_pop;

   // A word leaves the FIFO only on an edge where the FT600 actually took it.
   assign tx_accept  = !wr_n_q && !ft_txe_n;
   assign tx_full    = (tx_count == TX_FULL);
   assign tx_do_pop  = tx_accept && (tx_count != '0);
   assign tx_do_push = tx_en && (!tx_full || tx_do_pop);
   assign tx_count_after = tx_count + (TX_AW + 1)'(tx_do_push) - (TX_AW + 1)'(tx_do_pop);
   assign ft_data_o  = (tx_count != '0) ? tx_mem[tx_rd_ptr] : 16'h0000;

   // TX storage.
   always_ff @(posedge clk) begin
      if (tx_do_push) tx_mem[tx_wr_ptr] <= tx_data;
   end

   // TX pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
      end else begin
         if (tx_do_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
         if (tx_do_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
         tx_count <= tx_count_after;
      end
   end

   // ---------------- Bus sequencer ----------------
   logic rx_req, tx_req;

   // RX needs 4 free entries to start: enough for the words that can land
   // while the stop decision propagates through the registered strobe.
   assign rx_req    = !ft_rxf_n && (rx_free >= (RX_AW + 1)'(4));
   assign tx_req    = !ft_txe_n && (tx_count != '0);
   assign burst_inc = burst_cnt + BW'(rx_capture || tx_accept);

   // Next-state and next-strobe logic; strobes are registered below.
   always_comb begin
      state_n   = state;
      oe_n_n    = oe_n_q;
      rd_n_n    = rd_n_q;
      wr_n_n    = wr_n_q;
      data_oe_n = data_oe_q;
      burst_n   = burst_cnt;
      last_tx_n = last_tx;
      case (state)
         S_IDLE: begin
            oe_n_n    = 1'b1;
            rd_n_n    = 1'b1;
            wr_n_n    = 1'b1;
            data_oe_n = 1'b0;
            burst_n   = '0;
            // When both want the bus, the direction not served last wins.
            if (rx_req && (!tx_req || last_tx)) begin
               state_n   = S_RX_TURN;
               oe_n_n    = 1'b0;
               last_tx_n = 1'b0;
            end else if (tx_req) begin
               state_n   = S_TX_WRITE;
               data_oe_n = 1'b1;
               wr_n_n    = 1'b0;
               last_tx_n = 1'b1;
            end
         end
         S_RX_TURN: begin
            state_n = S_RX_READ;
            rd_n_n  = 1'b0;
         end
         S_RX_READ: begin
            burst_n = burst_inc;
            if (ft_rxf_n || (rx_free_after <= (RX_AW + 1)'(2)) ||
                (burst_inc == BW'(MAX_BURST))) begin
               state_n = S_RX_END;
               rd_n_n  = 1'b1;
            end
         end
         S_RX_END: begin
            burst_n = burst_inc;
            state_n = S_IDLE;
            oe_n_n  = 1'b1;
         end
         S_TX_WRITE: begin
            burst_n = burst_inc;
            if (ft_txe_n || (tx_count_after == '0) ||
                (burst_inc == BW'(MAX_BURST))) begin
               state_n   = S_TX_END;
               wr_n_n    = 1'b1;
               data_oe_n = 1'b0;
            end
         end
         S_TX_END: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n   = S_IDLE;
            oe_n_n    = 1'b1;
            rd_n_n    = 1'b1;
            wr_n_n    = 1'b1;
            data_oe_n = 1'b0;
         end
      endcase
   end

   // State, strobe and arbitration registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         oe_n_q    <= 1'b1;
         rd_n_q    <= 1'b1;
         wr_n_q    <= 1'b1;
         data_oe_q <= 1'b0;
         burst_cnt <= '0;
         last_tx   <= 1'b1;
      end else begin
         state     <= state_n;
         oe_n_q    <= oe_n_n;
         rd_n_q    <= rd_n_n;
         wr_n_q    <= wr_n_n;
         data_oe_q <= data_oe_n;
         burst_cnt <= burst_n;
         last_tx   <= last_tx_n;
      end
   end

   assign ft_oe_n    = oe_n_q;
   assign ft_rd_n    = rd_n_q;
   assign ft_wr_n    = wr_n_q;
   assign ft_data_oe = data_oe_q;
   assign ft_be_o    = 2'b11;

endmodule
